// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared types for the RV32M multiply/divide execute unit.
//   md_op_e    : RV32M funct3 encodings (MUL .. REMU)
//   md_state_e : sequencer states IDLE / MUL / DIV / DONE
//   cnt_width  : iteration counter width for a given XLEN (counts 0..XLEN)
//   CNT_W      : counter width for the default XLEN of 32
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  // One extra bit so the counter can hold XLEN itself without wrapping.
  function automatic int cnt_width(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

  localparam int CNT_W = cnt_width(32);

endpackage

// File: rtl/muldiv_div_iter.sv
// muldiv_div_iter -- one restoring-division step on unsigned magnitudes.
//   rem_in   : partial remainder (always < divisor)
//   quo_in   : dividend bits still to be shifted in, MSB first; quotient
//              bits enter at the LSB as the dividend drains out
//   divisor  : unsigned divisor (non-zero)
//   rem_out  : next partial remainder
//   quo_out  : next dividend/quotient shift word
module muldiv_div_iter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem_in < divisor, so shifted < 2*divisor and the MSB of diff is a
  // reliable borrow flag: set means the trial subtraction must be undone.
  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign rem_out = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_out = {quo_in[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU) with valid/ready on both sides and flush.
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   : op request / accept (ready only in IDLE)
//   funct3, src_a/src_b : operation and operands, captured at accept
//   rd_in / rd_out      : destination tag carried alongside the op
//   flush               : abort whatever is in flight, back to IDLE
//   out_valid/out_ready : result handshake; result/rd_out held while stalled
//   busy                : op accepted and result not yet consumed
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle array multiplier
// (result registered straight into DONE); otherwise a shift-add multiplier
// iterates XLEN cycles. Division is iterative in both builds.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  src_a,
  input  logic [XLEN-1:0]  src_b,
  input  logic [TAG_W-1:0] rd_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_out,
  output logic             busy
);

  localparam int CW = cnt_width(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(XLEN);

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // MUL: {partial product high, multiplier shifting out}.
  // DIV: {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   opb_q, opb_d;      // multiplicand or divisor magnitude
  logic              neg_q, neg_d;      // negate product / quotient
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [TAG_W-1:0]  rd_q, rd_d;

  // Input-side decode, used only in the accept cycle.
  md_op_e          op_in;
  logic            a_neg, b_neg, is_div_in, b_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  assign op_in     = md_op_e'(funct3);
  assign is_div_in = funct3[2];
  assign a_neg     = (op_in == MD_MULH || op_in == MD_MULHSU ||
                      op_in == MD_DIV  || op_in == MD_REM) && src_a[XLEN-1];
  assign b_neg     = (op_in == MD_MULH || op_in == MD_DIV ||
                      op_in == MD_REM) && src_b[XLEN-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;
  assign b_zero    = (src_b == '0);
  assign div_ovf   = (op_in == MD_DIV || op_in == MD_REM) &&
                     (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (&src_b);

  // Signed result of a magnitude product; MUL takes the low half, the
  // MULH variants the high half.
  function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p,
                                               input logic neg,
                                               input md_op_e op);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return (op == MD_MUL) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

  // Shift-add step: add the multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole word right (carry included).
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                    {1'b0, (prod_q[0] ? opb_q : {XLEN{1'b0}})};
  assign mul_next = {mul_sum, prod_q[XLEN-1:1]};

  logic [XLEN-1:0] div_rem, div_quo, quo_fix, rem_fix;

  muldiv_div_iter #(.XLEN(XLEN)) u_div_iter (
    .rem_in  (prod_q[2*XLEN-1:XLEN]),
    .quo_in  (prod_q[XLEN-1:0]),
    .divisor (opb_q),
    .rem_out (div_rem),
    .quo_out (div_quo)
  );

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quo_fix = neg_q     ? -prod_q[XLEN-1:0]      : prod_q[XLEN-1:0];
  assign rem_fix = neg_rem_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];

  always_comb begin
    // NOTE: every register defaults to holding its value, so no branch below
    // can leave a signal unassigned and infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    rd_d      = rd_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          op_d      = op_in;
          rd_d      = rd_in;
          cnt_d     = '0;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (is_div_in) begin
            prod_d = {{XLEN{1'b0}}, a_mag};
            opb_d  = b_mag;
            if (b_zero) begin
              state_d  = DONE;
              result_d = (op_in == MD_DIV || op_in == MD_DIVU) ? '1 : src_a;
            end else if (div_ovf) begin
              state_d  = DONE;
              result_d = (op_in == MD_DIV) ? src_a : '0;
            end else begin
              state_d = DIV;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            state_d  = DONE;
            result_d = mul_pick(fast_prod, a_neg ^ b_neg, op_in);
`else
            prod_d  = {{XLEN{1'b0}}, b_mag};
            opb_d   = a_mag;
            state_d = MUL;
`endif
          end
        end
        MUL: begin
          cnt_d  = cnt_q + 1'b1;
          prod_d = mul_next;
          if (cnt_q == CNT_LAST) begin
            state_d  = DONE;
            result_d = mul_pick(mul_next, neg_q, op_q);
          end
        end
        DIV: begin
          if (cnt_q == CNT_FULL) begin
            state_d  = DONE;
            result_d = (op_q == MD_DIV || op_q == MD_DIVU) ? quo_fix : rem_fix;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            prod_d = {div_rem, div_quo};
          end
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= MD_MUL;
      cnt_q     <= '0;
      prod_q    <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign rd_out    = rd_q;

endmodule
